// File: rtl/player_motion_pkg.sv
// Shared fixed-point types, FSM states and direction-table helpers for the player pose updater.
// Poses are signed Q6.10; the map is a 16x16 grid of 1.0-wide cells.
package player_motion_pkg;

    localparam int Qn           = 10;
    localparam int SF           = 1 << Qn;
    localparam int HEADING_BITS = 6;
    localparam int MAP_BITS     = 4;

    typedef logic signed [15:0]       fixed_t;
    typedef logic [HEADING_BITS-1:0]  heading_t;
    typedef logic [MAP_BITS-1:0]      cell_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_CHK_X,
        S_CHK_Y,
        S_COMMIT
    } state_e;

    // First quadrant of sin(k*2pi/64) scaled by 1024, k = 0..16.
    function automatic fixed_t quarter_sin(input logic [4:0] k);
        case (k)
            5'd0:    return 16'sd0;
            5'd1:    return 16'sd100;
            5'd2:    return 16'sd200;
            5'd3:    return 16'sd297;
            5'd4:    return 16'sd392;
            5'd5:    return 16'sd483;
            5'd6:    return 16'sd569;
            5'd7:    return 16'sd650;
            5'd8:    return 16'sd724;
            5'd9:    return 16'sd792;
            5'd10:   return 16'sd851;
            5'd11:   return 16'sd903;
            5'd12:   return 16'sd946;
            5'd13:   return 16'sd980;
            5'd14:   return 16'sd1004;
            5'd15:   return 16'sd1019;
            default: return 16'sd1024;
        endcase
    endfunction

    function automatic fixed_t dir_sin(input heading_t h);
        logic [4:0] k;
        fixed_t     mag;
        k   = {1'b0, h[3:0]};
        mag = h[4] ? quarter_sin(5'd16 - k) : quarter_sin(k);
        return h[5] ? -mag : mag;
    endfunction

    function automatic fixed_t half(input fixed_t v);
        return v >>> 1;
    endfunction

    function automatic logic signed [16:0] ext17(input fixed_t v);
        return {v[15], v};
    endfunction

    // Anything negative or at/after 16.0 lies outside the map.
    function automatic logic is_oob(input fixed_t v);
        return v[15:14] != 2'b00;
    endfunction

endpackage

// File: rtl/player_motion_if.sv
// Map ROM access port: request/grant arbitration plus combinational cell data.
// Handshake: map_req stays high until a cycle with map_gnt high; map_val is sampled in that cycle.
interface player_motion_if;
    import player_motion_pkg::*;

    logic       map_req;
    logic       map_gnt;
    cell_t      map_col;
    cell_t      map_row;
    logic [1:0] map_val;

    modport master (output map_req, map_col, map_row, input map_gnt, map_val);
    modport slave  (input map_req, map_col, map_row, output map_gnt, map_val);

endinterface

// File: rtl/player_motion_dir_lut.sv
// Heading index to unit direction vector (cos, sin) in Q6.10, folded from a quarter-wave table.
module player_motion_dir_lut
    import player_motion_pkg::*;
(
    input  heading_t heading_i,
    output fixed_t   cos_o,
    output fixed_t   sin_o
);

    assign sin_o = dir_sin(heading_i);
    assign cos_o = dir_sin(heading_i + heading_t'(16));

endmodule

// File: rtl/player_motion.sv
// Per-frame pose updater: turn, then move/strafe with per-axis wall and bounds checks,
// committing position, facing and camera plane together in one cycle.
module player_motion
    import player_motion_pkg::*;
#(
    parameter int START_CELL_X  = 1,
    parameter int START_CELL_Y  = 11,
    parameter int START_HEADING = 48,
    parameter int STEP_SHIFT    = 7
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  logic   moveL,
    input  logic   moveR,
    input  logic   moveF,
    input  logic   moveB,
    input  logic   turnL,
    input  logic   turnR,
    player_motion_if.master map,
    output fixed_t playerX,
    output fixed_t playerY,
    output fixed_t facingX,
    output fixed_t facingY,
    output fixed_t vplaneX,
    output fixed_t vplaneY,
    output logic   busy,
    output logic   done,
    output state_e state_dbg
);

    localparam fixed_t   RST_PX = fixed_t'((START_CELL_X << Qn) + SF / 2);
    localparam fixed_t   RST_PY = fixed_t'((START_CELL_Y << Qn) + SF / 2);
    localparam heading_t RST_H  = heading_t'(START_HEADING);
    localparam fixed_t   RST_FX = dir_sin(RST_H + heading_t'(16));
    localparam fixed_t   RST_FY = dir_sin(RST_H);
    localparam fixed_t   RST_VX = half(-RST_FY);
    localparam fixed_t   RST_VY = half(RST_FX);

    state_e   state_q;
    heading_t heading_q, heading_d;
    fixed_t   px_q, py_q, fx_q, fy_q, vx_q, vy_q;
    fixed_t   wfx_q, wfy_q, wvx_q, wvy_q;
    fixed_t   cx_q, cy_q, nx_q;
    logic     busy_q, done_q, req_q;
    cell_t    col_q, row_q;

    fixed_t              lut_cos, lut_sin, vpx_d, vpy_d, cx_d, cy_d, nx_d, ny_d;
    logic signed [16:0]  sum_x, sum_y;
    logic                wall;

    player_motion_dir_lut u_lut (
        .heading_i (heading_d),
        .cos_o     (lut_cos),
        .sin_o     (lut_sin)
    );

    // Movement uses the post-turn heading, so the LUT is fed the next heading.
    always_comb begin
        heading_d = heading_q;
        if (turnL)      heading_d = heading_q - heading_t'(1);
        else if (turnR) heading_d = heading_q + heading_t'(1);

        vpx_d = half(-lut_sin);
        vpy_d = half(lut_cos);

        sum_x = '0;
        sum_y = '0;
        if (moveF) begin
            sum_x = ext17(lut_cos);
            sum_y = ext17(lut_sin);
        end else if (moveB) begin
            sum_x = -ext17(lut_cos);
            sum_y = -ext17(lut_sin);
        end
        if (moveL) begin
            sum_x = sum_x - (ext17(vpx_d) <<< 1);
            sum_y = sum_y - (ext17(vpy_d) <<< 1);
        end else if (moveR) begin
            sum_x = sum_x + (ext17(vpx_d) <<< 1);
            sum_y = sum_y + (ext17(vpy_d) <<< 1);
        end

        cx_d = px_q + fixed_t'(sum_x >>> STEP_SHIFT);
        cy_d = py_q + fixed_t'(sum_y >>> STEP_SHIFT);

        wall = map.map_val != 2'd0;
        nx_d = (is_oob(cx_q) || wall) ? px_q : cx_q;
        ny_d = (is_oob(cy_q) || wall) ? py_q : cy_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            heading_q <= RST_H;
            px_q      <= RST_PX;
            py_q      <= RST_PY;
            fx_q      <= RST_FX;
            fy_q      <= RST_FY;
            vx_q      <= RST_VX;
            vy_q      <= RST_VY;
            wfx_q     <= '0;
            wfy_q     <= '0;
            wvx_q     <= '0;
            wvy_q     <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            nx_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_q     <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    heading_q <= heading_d;
                    wfx_q     <= lut_cos;
                    wfy_q     <= lut_sin;
                    wvx_q     <= vpx_d;
                    wvy_q     <= vpy_d;
                    cx_q      <= cx_d;
                    cy_q      <= cy_d;
                    req_q     <= ~is_oob(cx_d);
                    col_q     <= cx_d[13:10];
                    row_q     <= py_q[13:10];
                    state_q   <= S_CHK_X;
                end
                // An out-of-bounds candidate never asks for the map, so no grant is awaited.
                S_CHK_X: begin
                    if (is_oob(cx_q) || map.map_gnt) begin
                        nx_q    <= nx_d;
                        req_q   <= ~is_oob(cy_q);
                        col_q   <= nx_d[13:10];
                        row_q   <= cy_q[13:10];
                        state_q <= S_CHK_Y;
                    end
                end
                S_CHK_Y: begin
                    if (is_oob(cy_q) || map.map_gnt) begin
                        px_q    <= nx_q;
                        py_q    <= ny_d;
                        fx_q    <= wfx_q;
                        fy_q    <= wfy_q;
                        vx_q    <= wvx_q;
                        vy_q    <= wvy_q;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign playerX     = px_q;
    assign playerY     = py_q;
    assign facingX     = fx_q;
    assign facingY     = fy_q;
    assign vplaneX     = vx_q;
    assign vplaneY     = vy_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state_dbg   = state_q;
    assign map.map_req = req_q;
    assign map.map_col = col_q;
    assign map.map_row = row_q;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: directed frame scenarios plus random frames
// compared against a trigonometric reference model of the pose rules.
module tb_player_motion;
    import player_motion_pkg::*;

    localparam real PI = 3.14159265358979323846;

    logic   clk = 1'b0;
    logic   reset, start;
    logic   moveL, moveR, moveF, moveB, turnL, turnR;
    logic   gnt;
    fixed_t playerX, playerY, facingX, facingY, vplaneX, vplaneY;
    logic   busy, done;
    state_e dbg;

    logic [1:0]  map_mem [0:15][0:15];
    logic [15:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          m_px, m_py, m_h;

    wire [95:0] pose_w = {playerX, playerY, facingX, facingY, vplaneX, vplaneY};

    player_motion_if bus ();
    assign bus.map_gnt = gnt;
    assign bus.map_val = map_mem[bus.map_row][bus.map_col];

    always #5 clk = ~clk;

    player_motion dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .moveL     (moveL),
        .moveR     (moveR),
        .moveF     (moveF),
        .moveB     (moveB),
        .turnL     (turnL),
        .turnR     (turnR),
        .map       (bus.master),
        .playerX   (playerX),
        .playerY   (playerY),
        .facingX   (facingX),
        .facingY   (facingY),
        .vplaneX   (vplaneX),
        .vplaneY   (vplaneY),
        .busy      (busy),
        .done      (done),
        .state_dbg (dbg)
    );

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic int rnd(input real r);
        return $rtoi($floor(r + 0.5));
    endfunction

    task automatic model_reset();
        m_px = 1 * 1024 + 512;
        m_py = 11 * 1024 + 512;
        m_h  = 48;
        exp_q.delete();
    endtask

    // Reference: unit vector from real trig, camera plane at half length, step = vector/128 (floored).
    task automatic model_frame(input logic [5:0] btn);
        int c, s, vx, vy, sx, sy, cx, cy, nx, ny;
        if (btn[5])      m_h = (m_h + 63) % 64;
        else if (btn[4]) m_h = (m_h + 1) % 64;
        c  = rnd(1024.0 * $cos(2.0 * PI * real'(m_h) / 64.0));
        s  = rnd(1024.0 * $sin(2.0 * PI * real'(m_h) / 64.0));
        vx = (-s) >>> 1;
        vy = c >>> 1;
        sx = 0;
        sy = 0;
        if (btn[3])      begin sx = c;  sy = s;  end
        else if (btn[2]) begin sx = -c; sy = -s; end
        if (btn[1])      begin sx = sx - 2 * vx; sy = sy - 2 * vy; end
        else if (btn[0]) begin sx = sx + 2 * vx; sy = sy + 2 * vy; end
        cx = m_px + (sx >>> 7);
        cy = m_py + (sy >>> 7);
        nx = m_px;
        if (cx >= 0 && cx < 16384)
            if (map_mem[m_py / 1024][cx / 1024] == 2'd0) nx = cx;
        ny = m_py;
        if (cy >= 0 && cy < 16384)
            if (map_mem[cy / 1024][nx / 1024] == 2'd0) ny = cy;
        m_px = nx;
        m_py = ny;
        exp_q.push_back(16'(nx));
        exp_q.push_back(16'(ny));
        exp_q.push_back(16'(c));
        exp_q.push_back(16'(s));
        exp_q.push_back(16'(vx));
        exp_q.push_back(16'(vy));
    endtask

    task automatic apply_reset();
        start = 0; gnt = 1;
        {turnL, turnR, moveF, moveB, moveL, moveR} = 6'b0;
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        model_reset();
    endtask

    task automatic clear_map();
        foreach (map_mem[r, c]) map_mem[r][c] = 2'd0;
    endtask

    // btn = {turnL, turnR, moveF, moveB, moveL, moveR}; gmode 0 grant tied high,
    // 1 random grant, 2 grant held low for `hold` cycles of the X check.
    task automatic do_frame(input logic [5:0] btn, input int gmode, input int hold,
                            output int lat, output logic req_x, output logic req_y);
        logic [95:0] pre;
        logic [15:0] got [6];
        logic [15:0] want;
        string       nm [6] = '{"playerX", "playerY", "facingX", "facingY", "vplaneX", "vplaneY"};
        int          cyc;
        bit          got_x, got_y;
        req_x = 0; req_y = 0; got_x = 0; got_y = 0;
        @(negedge clk);
        {turnL, turnR, moveF, moveB, moveL, moveR} = btn;
        if (gmode == 2) gnt = 0;
        start = 1;
        pre = pose_w;
        @(negedge clk);
        start = 0;
        cyc = 1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_calc got=%b exp=1", busy); end
        while (done !== 1'b1 && cyc < 200) begin
            checks++;
            if (pose_w !== pre) begin
                errors++;
                $display("FAIL frozen cyc=%0d got=%h exp=%h", cyc, pose_w, pre);
            end
            if (dbg == S_CHK_X && !got_x) begin req_x = bus.map_req; got_x = 1; end
            if (dbg == S_CHK_Y && !got_y) begin req_y = bus.map_req; got_y = 1; end
            if (gmode == 2 && cyc >= 2 && cyc < 2 + hold) begin
                checks++;
                if (bus.map_req !== 1'b1) begin
                    errors++;
                    $display("FAIL req_wait cyc=%0d got=%b exp=1", cyc, bus.map_req);
                end
            end
            if (gmode == 2 && cyc == 2 + hold) gnt = 1;
            if (gmode == 1) gnt = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL done_timeout got=%b exp=1", done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_commit got=%b exp=0", busy); end
        model_frame(btn);
        got = '{playerX, playerY, facingX, facingY, vplaneX, vplaneY};
        for (int i = 0; i < 6; i++) begin
            want = exp_q.pop_front();
            checks++;
            if (got[i] !== want) begin
                errors++;
                $display("FAIL pose_%s got=%h exp=%h", nm[i], got[i], want);
            end
        end
        {turnL, turnR, moveF, moveB, moveL, moveR} = 6'b0;
        gnt = 1;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_reset();
        logic [15:0] got [6];
        logic [15:0] want [6] = '{16'h0600, 16'h2E00, 16'h0000, 16'hFC00, 16'h0200, 16'h0000};
        apply_reset();
        got = '{playerX, playerY, facingX, facingY, vplaneX, vplaneY};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL reset_pose%0d got=%h exp=%h", i, got[i], want[i]);
            end
        end
        checks++;
        if ({busy, done, bus.map_req} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000", {busy, done, bus.map_req});
        end
        checks++;
        if (dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg, S_IDLE); end
    endtask

    task automatic test_move_forward();
        int lat; logic rx, ry;
        apply_reset(); clear_map();
        do_frame(6'b001000, 0, 0, lat, rx, ry);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL fwd_latency got=%0d exp=4", lat); end
        checks++;
        if ({playerX, playerY} !== {16'h0600, 16'h2DF8}) begin
            errors++;
            $display("FAIL fwd_pos got=%h_%h exp=0600_2df8", playerX, playerY);
        end
        checks++;
        if ({rx, ry} !== 2'b11) begin errors++; $display("FAIL fwd_reads got=%b exp=11", {rx, ry}); end
    endtask

    task automatic test_turn();
        int lat; logic rx, ry;
        apply_reset(); clear_map();
        for (int i = 0; i < 16; i++) do_frame(6'b010000, 0, 0, lat, rx, ry);
        checks++;
        if ({facingX, facingY, vplaneX, vplaneY} !== {16'd1024, 16'd0, 16'd0, 16'd512}) begin
            errors++;
            $display("FAIL turn_dir got=%h_%h_%h_%h exp=0400_0000_0000_0200",
                     facingX, facingY, vplaneX, vplaneY);
        end
        checks++;
        if ({playerX, playerY} !== {16'h0600, 16'h2E00}) begin
            errors++;
            $display("FAIL turn_pos got=%h_%h exp=0600_2e00", playerX, playerY);
        end
    endtask

    task automatic test_wall();
        int lat; logic rx, ry;
        apply_reset(); clear_map();
        map_mem[11][0] = 2'd1;
        for (int i = 0; i < 16; i++) do_frame(6'b100000, 0, 0, lat, rx, ry);
        for (int i = 0; i < 70; i++) do_frame(6'b001000, 0, 0, lat, rx, ry);
        checks++;
        if (playerX !== 16'h0400) begin errors++; $display("FAIL wall_x got=%h exp=0400", playerX); end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL wall_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_oob();
        int lat; logic rx, ry;
        apply_reset(); clear_map();
        for (int i = 0; i < 196; i++) do_frame(6'b000010, 0, 0, lat, rx, ry);
        checks++;
        if (playerX !== 16'h0000) begin errors++; $display("FAIL oob_x got=%h exp=0000", playerX); end
        checks++;
        if ({rx, ry} !== 2'b01) begin errors++; $display("FAIL oob_reads got=%b exp=01", {rx, ry}); end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL oob_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_grant_wait();
        int lat; logic rx, ry;
        apply_reset(); clear_map();
        do_frame(6'b001000, 2, 10, lat, rx, ry);
        checks++;
        if (lat !== 14) begin errors++; $display("FAIL wait_latency got=%0d exp=14", lat); end
    endtask

    task automatic test_reset_midop();
        int lat, n, seen; logic rx, ry;
        apply_reset(); clear_map();
        do_frame(6'b001000, 0, 0, lat, rx, ry);
        @(negedge clk);
        moveF = 1; start = 1;
        @(negedge clk);
        start = 0; n = 0;
        while (dbg != S_CHK_Y && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (dbg != S_CHK_Y) begin errors++; $display("FAIL midop_reach got=%0d exp=%0d", dbg, S_CHK_Y); end
        #1 reset = 1;
        #1;
        checks++;
        if ({playerX, playerY, facingY} !== {16'h0600, 16'h2E00, 16'hFC00}) begin
            errors++;
            $display("FAIL midop_pose got=%h_%h_%h exp=0600_2e00_fc00", playerX, playerY, facingY);
        end
        checks++;
        if ({bus.map_req, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL midop_flags got=%b exp=000", {bus.map_req, busy, done});
        end
        repeat (2) @(negedge clk);
        reset = 0; moveF = 0;
        model_reset();
        seen = 0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (done === 1'b1) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midop_nodone got=%0d exp=0", seen); end
        do_frame(6'b001000, 0, 0, lat, rx, ry);
    endtask

    task automatic test_random();
        int lat; logic rx, ry;
        apply_reset();
        foreach (map_mem[r, c])
            map_mem[r][c] = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        map_mem[11][1] = 2'd0;
        for (int i = 0; i < 150; i++) do_frame(6'($urandom_range(0, 63)), 1, 0, lat, rx, ry);
    endtask

    initial begin
        test_reset();
        test_move_forward();
        test_turn();
        test_wall();
        test_oob();
        test_grant_wait();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
